vdp_cpu_bus_bridge: RTL and testbench

// - Parametrised successor to the inline CPU-port logic of the VDP top: strobe sync + glitch filter, write FIFO, REQ/ACK drain to VDP core.
// - Sits between host pins (csr_n/csw_n/mode/cd) and the VDP register port (REQ/WRT/ADR/DBO/DBI/ACK), all in clk_w.
// - Exactly one VDP access per host strobe: status reads clear flags, so no duplicate reads.

---
 rtl/vdp_cpu_bus_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_vdp_cpu_bus_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_bus_bridge.sv
// Host CPU port to VDP register-port bridge: strobe sync and glitch filter, write FIFO, REQ/ACK drain.
// Optional VDP_BRIDGE_STATS_EN adds saturating write/read/drop counters.
module vdp_cpu_bus_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                        clk_w,
    input  logic                        reset_n_w,
    input  logic                        csr_n,
    input  logic                        csw_n,
    input  logic [ADDR_W-1:0]           mode,
    input  logic [7:0]                  cd_in,
    output logic [7:0]                  cd_out,
    output logic                        cd_oe,
    output logic                        vdp_req,
    output logic                        vdp_wrt,
    output logic [ADDR_W-1:0]           vdp_adr,
    output logic [7:0]                  vdp_dbo,
    input  logic [7:0]                  vdp_dbi,
    input  logic                        vdp_ack,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [2:0]                  err_flags
`ifdef VDP_BRIDGE_STATS_EN
    ,
    output logic [15:0]                 wr_count,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 drop_count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [7:0]        dat;
    } wr_entry_t;

    // Index 0 = read strobe, index 1 = write strobe.
    logic [1:0]             w_raw;
    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [CNT_W-1:0]       r_fcnt [2];
    logic [1:0]             r_flt;
    logic [1:0]             w_flip;
    logic [1:0]             w_flt_nxt;

    wr_entry_t              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wp;
    logic [PTR_W-1:0]       r_rp;
    logic [LVL_W-1:0]       r_level;
    wr_entry_t              w_head;

    state_t                 r_state;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_rd_pend;
    logic [ADDR_W-1:0]      r_rd_adr;
    logic [2:0]             r_err;

    logic w_wr_fall, w_rd_fall, w_coll, w_push_req, w_rd_set, w_full;
    logic w_push, w_ovf, w_tmo_hit, w_pop, w_rd_done, w_rd_clr, w_tmo_evt;

    assign w_raw = {csw_n, csr_n};

    // Filtered level flips on the FILTER_LEN-th consecutive differing synced sample.
    always_comb begin
        w_flip    = '0;
        w_flt_nxt = r_flt;
        for (int i = 0; i < 2; i++) begin
            w_flip[i]    = (r_sync[i][SYNC_STAGES-1] != r_flt[i]) &&
                           (r_fcnt[i] == CNT_W'(FILTER_LEN - 1));
            w_flt_nxt[i] = r_flt[i] ^ w_flip[i];
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= '1;
                r_fcnt[i] <= '0;
            end
            r_flt <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (r_sync[i][SYNC_STAGES-1] == r_flt[i] || w_flip[i]) begin
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + CNT_W'(1);
                end
            end
            r_flt <= w_flt_nxt;
        end
    end

    // A strobe falling while the other strobe is (or becomes) low is a collision.
    assign w_wr_fall  = w_flip[1] & ~w_flt_nxt[1];
    assign w_rd_fall  = w_flip[0] & ~w_flt_nxt[0];
    assign w_coll     = (w_wr_fall | w_rd_fall) & ~w_flt_nxt[0] & ~w_flt_nxt[1];
    assign w_push_req = w_wr_fall & w_flt_nxt[0];
    assign w_rd_set   = w_rd_fall & w_flt_nxt[1];
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push     = w_push_req & ~w_full;
    assign w_ovf      = w_push_req & w_full;
    assign w_head     = r_mem[r_rp];

    assign w_tmo_hit  = (r_tmo == TMO_W'(ACK_TIMEOUT - 1));
    assign w_pop      = (r_state == ST_WR) & (vdp_ack | w_tmo_hit);
    assign w_rd_done  = (r_state == ST_RD) & vdp_ack;
    assign w_rd_clr   = (r_state == ST_RD) & (vdp_ack | w_tmo_hit);
    assign w_tmo_evt  = (r_state != ST_IDLE) & ~vdp_ack & w_tmo_hit;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= '{adr: mode, dat: cd_in};
                r_wp        <= r_wp + PTR_W'(1);
            end
            if (w_pop) r_rp <= r_rp + PTR_W'(1);
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // Drain FSM: queued writes always go out before a pending read.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_adr  <= '0;
            r_err     <= '0;
            vdp_req   <= 1'b0;
            vdp_wrt   <= 1'b0;
            vdp_adr   <= '0;
            vdp_dbo   <= '0;
            cd_out    <= 8'hFF;
        end else begin
            r_err <= r_err | {w_tmo_evt, w_coll, w_ovf};
            if (w_rd_set) begin
                r_rd_pend <= 1'b1;
                r_rd_adr  <= mode;
            end else if (w_rd_clr) begin
                r_rd_pend <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (r_level != '0) begin
                        r_state <= ST_WR;
                        vdp_req <= 1'b1;
                        vdp_wrt <= 1'b1;
                        vdp_adr <= w_head.adr;
                        vdp_dbo <= w_head.dat;
                    end else if (r_rd_pend) begin
                        r_state <= ST_RD;
                        vdp_req <= 1'b1;
                        vdp_wrt <= 1'b0;
                        vdp_adr <= r_rd_adr;
                        vdp_dbo <= '0;
                    end
                end
                ST_WR, ST_RD: begin
                    if (vdp_ack || w_tmo_hit) begin
                        if (r_state == ST_RD && vdp_ack) cd_out <= vdp_dbi;
                        r_state <= ST_IDLE;
                        r_tmo   <= '0;
                        vdp_req <= 1'b0;
                        vdp_wrt <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    vdp_req <= 1'b0;
                end
            endcase
        end
    end

    assign cd_oe      = ~csr_n;
    assign fifo_level = r_level;
    assign err_flags  = r_err;

`ifdef VDP_BRIDGE_STATS_EN
    logic [15:0] r_wr_cnt, r_rd_cnt, r_drop_cnt;
    logic [1:0]  w_drop_n;
    logic [16:0] w_drop_sum;

    assign w_drop_n   = 2'(w_ovf) + 2'(w_coll) + 2'(w_tmo_evt);
    assign w_drop_sum = 17'(r_drop_cnt) + 17'(w_drop_n);

    // Saturating activity counters.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_rd_done && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign wr_count   = r_wr_cnt;
    assign rd_count   = r_rd_cnt;
    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_vdp_cpu_bus_bridge.sv
// Directed self-checking bench for vdp_cpu_bus_bridge (default parameters).
module tb_vdp_cpu_bus_bridge;

    localparam int unsigned ACK_DLY = 2;

    logic       clk_w = 1'b0;
    logic       reset_n_w;
    logic       csr_n, csw_n;
    logic [1:0] mode;
    logic [7:0] cd_in;
    logic [7:0] cd_out;
    logic       cd_oe;
    logic       vdp_req, vdp_wrt;
    logic [1:0] vdp_adr;
    logic [7:0] vdp_dbo;
    logic [7:0] vdp_dbi;
    logic       vdp_ack;
    logic [2:0] fifo_level;
    logic [2:0] err_flags;
`ifdef VDP_BRIDGE_STATS_EN
    logic [15:0] wr_count, rd_count, drop_count;
`endif

    vdp_cpu_bus_bridge dut (
        .clk_w      (clk_w),
        .reset_n_w  (reset_n_w),
        .csr_n      (csr_n),
        .csw_n      (csw_n),
        .mode       (mode),
        .cd_in      (cd_in),
        .cd_out     (cd_out),
        .cd_oe      (cd_oe),
        .vdp_req    (vdp_req),
        .vdp_wrt    (vdp_wrt),
        .vdp_adr    (vdp_adr),
        .vdp_dbo    (vdp_dbo),
        .vdp_dbi    (vdp_dbi),
        .vdp_ack    (vdp_ack),
        .fifo_level (fifo_level),
`ifdef VDP_BRIDGE_STATS_EN
        .wr_count   (wr_count),
        .rd_count   (rd_count),
        .drop_count (drop_count),
`endif
        .err_flags  (err_flags)
    );

    always #5 clk_w = ~clk_w;

    typedef struct packed {
        logic       wrt;
        logic [1:0] adr;
        logic [7:0] dat;
    } txn_t;

    txn_t log_q[$];
    int   req_rises = 0;
    logic ack_en    = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_w);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n_w = 1'b0;
        csr_n     = 1'b1;
        csw_n     = 1'b1;
        tick(3);
        reset_n_w = 1'b1;
        tick(2);
    endtask

    task automatic host_write(input logic [1:0] m, input logic [7:0] d, input int hold);
        mode  = m;
        cd_in = d;
        csw_n = 1'b0;
        tick(hold);
        csw_n = 1'b1;
        tick(hold);
    endtask

    // VDP model: acks ACK_DLY samples after request seen, logs each completed access.
    initial begin : vdp_model
        int   age;
        logic prev_req;
        txn_t t;
        age      = 0;
        prev_req = 1'b0;
        vdp_ack  = 1'b0;
        forever begin
            @(posedge clk_w);
            #1;
            vdp_ack = 1'b0;
            if (vdp_req && !prev_req) req_rises++;
            prev_req = vdp_req;
            if (vdp_req && ack_en) begin
                age++;
                if (age == ACK_DLY) begin
                    vdp_ack = 1'b1;
                    age     = 0;
                    t.wrt   = vdp_wrt;
                    t.adr   = vdp_adr;
                    t.dat   = vdp_dbo;
                    log_q.push_back(t);
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin : stim
        int base, r0, n;
        logic [7:0] wdat [3];
        logic [1:0] wadr [3];
        wdat[0] = 8'h12; wdat[1] = 8'h34; wdat[2] = 8'h56;
        wadr[0] = 2'd0;  wadr[1] = 2'd1;  wadr[2] = 2'd1;

        reset_n_w = 1'b0;
        csr_n = 1'b1; csw_n = 1'b1; mode = '0; cd_in = '0; vdp_dbi = 8'hA5;
        tick(2);
        chk("rst_req",   32'(vdp_req),    32'd0);
        chk("rst_cdout", 32'(cd_out),     32'hFF);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_err",   32'(err_flags),  32'd0);
        chk("rst_cdoe",  32'(cd_oe),      32'd0);
        reset_n_w = 1'b1;
        tick(2);

        // Write burst, acked by the model.
        ack_en = 1'b1;
        base = log_q.size();
        for (int i = 0; i < 3; i++) host_write(wadr[i], wdat[i], 8);
        tick(6);
        chk("burst_count", 32'(log_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (log_q.size() > base + i) begin
                chk("burst_wrt", 32'(log_q[base+i].wrt), 32'd1);
                chk("burst_adr", 32'(log_q[base+i].adr), 32'(wadr[i]));
                chk("burst_dat", 32'(log_q[base+i].dat), 32'(wdat[i]));
            end
        end
        chk("burst_level", 32'(fifo_level), 32'd0);
        chk("burst_err",   32'(err_flags),  32'd0);

        // Glitch shorter than the filter.
        r0 = req_rises;
        csw_n = 1'b0;
        tick(2);
        csw_n = 1'b1;
        tick(20);
        chk("glitch_reqs",  32'(req_rises - r0), 32'd0);
        chk("glitch_level", 32'(fifo_level),     32'd0);

        // Read after write.
        base = log_q.size();
        r0   = req_rises;
        host_write(2'd1, 8'h3C, 8);
        mode  = 2'd0;
        csr_n = 1'b0;
        tick(8);
        chk("rd_cdoe", 32'(cd_oe), 32'd1);
        csr_n = 1'b1;
        tick(10);
        chk("raw_reqs", 32'(req_rises - r0), 32'd2);
        chk("raw_count", 32'(log_q.size() - base), 32'd2);
        if (log_q.size() >= base + 2) begin
            chk("raw_first_wrt",  32'(log_q[base].wrt),   32'd1);
            chk("raw_first_adr",  32'(log_q[base].adr),   32'd1);
            chk("raw_first_dat",  32'(log_q[base].dat),   32'h3C);
            chk("raw_second_wrt", 32'(log_q[base+1].wrt), 32'd0);
            chk("raw_second_adr", 32'(log_q[base+1].adr), 32'd0);
        end
        chk("raw_cdout", 32'(cd_out), 32'hA5);

        // Overflow: no acks, five writes into a four-deep FIFO.
        do_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) host_write(2'(i), 8'(i + 1), 6);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_err",   32'(err_flags),  32'b001);
        chk("ovf_head_req", 32'(vdp_req), 32'd1);
        chk("ovf_head_dat", 32'(vdp_dbo), 32'h01);

        // Collision.
        do_reset();
        ack_en = 1'b1;
        r0 = req_rises;
        csr_n = 1'b0;
        csw_n = 1'b0;
        tick(8);
        csr_n = 1'b1;
        csw_n = 1'b1;
        tick(10);
        chk("coll_reqs",  32'(req_rises - r0), 32'd0);
        chk("coll_err",   32'(err_flags),      32'b010);
        chk("coll_level", 32'(fifo_level),     32'd0);

        // Timeout: request held for exactly ACK_TIMEOUT cycles.
        do_reset();
        ack_en = 1'b0;
        mode  = 2'd2;
        cd_in = 8'h99;
        csw_n = 1'b0;
        n = 0;
        while (!vdp_req && n < 40) begin
            n++;
            tick(1);
        end
        chk("tmo_req_up", 32'(vdp_req), 32'd1);
        n = 0;
        while (vdp_req && n < 200) begin
            if (n == 8) csw_n = 1'b1;
            n++;
            tick(1);
        end
        csw_n = 1'b1;
        chk("tmo_req_len", 32'(n),          32'd64);
        chk("tmo_err",     32'(err_flags),  32'b100);
        chk("tmo_level",   32'(fifo_level), 32'd0);

        // Reset in the middle of a request.
        mode  = 2'd3;
        cd_in = 8'h5A;
        csw_n = 1'b0;
        n = 0;
        while (!vdp_req && n < 40) begin
            n++;
            tick(1);
        end
        chk("mid_req_up", 32'(vdp_req), 32'd1);
        reset_n_w = 1'b0;
        #1;
        chk("mid_rst_req",   32'(vdp_req),    32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_err",   32'(err_flags),  32'd0);
        csw_n = 1'b1;
        tick(2);
        reset_n_w = 1'b1;
        tick(12);
        chk("post_rst_req", 32'(vdp_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
